// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encodings and default line settings.
// The transmitter imports the same package.
package uart_rx_pkg;

    localparam int unsigned DEF_CLK_FREQ = 100000000;
    localparam int unsigned DEF_BAUD     = 115200;

    localparam int unsigned ST_W = 3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser for an asynchronous input.
// Both flops reset to 1, which is the idle level of a serial line.
module uart_sync2 (
    input  logic CLK,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1; mid-bit sampling of a synchronised RXD line.
// Define UART_RX_PARITY_EN to add an even-parity bit and the rx_perr output.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
    parameter int unsigned BAUD     = DEF_BAUD
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       RXD,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr,
`ifdef UART_RX_PARITY_EN
    output logic       rx_perr,
`endif
    output logic       rx_busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned HALF         = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

    logic             w_rxs;
    logic [ST_W-1:0]  r_state;
    logic [ST_W-1:0]  w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic [7:0]       r_data;
    logic [7:0]       w_data_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_ferr;
    logic             w_ferr_nxt;
    logic             r_busy;
    logic [1:0]       r_live;
    logic             r_armed;
    logic             w_cnt_half;
    logic             w_cnt_last;
    logic             r_par;
    logic             w_par_nxt;
    logic             r_perr;
    logic             w_perr_nxt;

    uart_sync2 u_sync (
        .CLK   (CLK),
        .reset (reset),
        .i_d   (RXD),
        .o_q   (w_rxs)
    );

    assign w_cnt_half = (r_cnt == CNT_W'(HALF - 1));
    assign w_cnt_last = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Next-state and output decode; every state entry clears the baud counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        w_par_nxt   = r_par;
        w_perr_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_rxs && r_armed) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_cnt_half) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = w_rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_cnt_last) begin
                    w_cnt_nxt            = '0;
                    w_shift_nxt[r_idx]   = w_rxs;
                    w_idx_nxt            = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_cnt_last) begin
                    w_cnt_nxt   = '0;
                    w_par_nxt   = w_rxs;
                    w_state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_cnt_last) begin
                    w_cnt_nxt = '0;
                    if (w_rxs) begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                        w_perr_nxt  = ^{r_shift, r_par};
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                w_cnt_nxt = '0;
                if (w_rxs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // The line must be seen idle after the synchroniser flushes its reset
    // value, so a frame interrupted by reset cannot masquerade as a start bit.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
            r_live  <= 2'b00;
            r_armed <= 1'b0;
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_live  <= {r_live[0], 1'b1};
            r_armed <= r_armed | (r_live[1] & w_rxs);
            r_par   <= w_par_nxt;
            r_perr  <= w_perr_nxt;
        end
    end

    assign rx_data  = r_data;
    assign rx_valid = r_valid;
    assign rx_ferr  = r_ferr;
    assign rx_busy  = r_busy;
`ifdef UART_RX_PARITY_EN
    assign rx_perr  = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit; table of whole frames
// plus hand-written back-to-back, glitch, and mid-frame reset sequences.
module tb_uart_rx;

    localparam int CPB  = 10;
`ifdef UART_RX_PARITY_EN
    localparam int LAT  = 108;
`else
    localparam int LAT  = 98;
`endif

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         hold;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic       RXD = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferr;
    logic       rx_busy;
`ifdef UART_RX_PARITY_EN
    logic       rx_perr;
`endif

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int t_start = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int n_perr = 0;
    int n_both = 0;
    int n_busy_hi = 0;
    int busy_lo = 0;
    int lat = 0;
    bit meas = 1'b0;
    logic [7:0] cap [$];

    uart_rx #(
        .CLK_FREQ (1000000),
        .BAUD     (100000)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .RXD      (RXD),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr),
`ifdef UART_RX_PARITY_EN
        .rx_perr  (rx_perr),
`endif
        .rx_busy  (rx_busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (rx_valid) begin
            n_valid++;
            cap.push_back(rx_data);
            lat = cyc - t_start;
        end
        if (rx_ferr) n_ferr++;
`ifdef UART_RX_PARITY_EN
        if (rx_valid && rx_perr) n_perr++;
`endif
        if (rx_valid && rx_ferr) n_both++;
        if (rx_busy) n_busy_hi++;
        if (meas && !rx_busy) busy_lo++;
    end

    function automatic void chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void clr();
        n_valid = 0;
        n_ferr = 0;
        n_perr = 0;
        n_busy_hi = 0;
        cap.delete();
    endfunction

    // Caller is at a negedge; drives one frame starting immediately.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                              input int hold);
        RXD = 1'b0;
        t_start = cyc;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RXD = d[i];
            repeat (CPB) @(negedge CLK);
        end
`ifdef UART_RX_PARITY_EN
        RXD = par;
        repeat (CPB) @(negedge CLK);
`else
        if (par) RXD = 1'b1;
`endif
        RXD = stop;
        repeat (CPB) @(negedge CLK);
        if (hold > 0) repeat (hold) @(negedge CLK);
        RXD = 1'b1;
    endtask

    vec_t vt [6];

    initial begin
        vt[0] = '{8'h55, 1'b1, 0,  1, 0, 8'h55};
        vt[1] = '{8'h00, 1'b1, 0,  1, 0, 8'h00};
        vt[2] = '{8'hA5, 1'b0, 30, 0, 1, 8'h00};
        vt[3] = '{8'h3C, 1'b1, 0,  1, 0, 8'h3C};
        vt[4] = '{8'hFF, 1'b1, 0,  1, 0, 8'hFF};
        vt[5] = '{8'h81, 1'b1, 0,  1, 0, 8'h81};

        repeat (3) @(negedge CLK);
        chk("reset rx_data", int'(rx_data), 8'h00);
        chk("reset rx_valid", int'(rx_valid), 0);
        chk("reset rx_ferr", int'(rx_ferr), 0);
        chk("reset rx_busy", int'(rx_busy), 0);
        reset = 1'b1;
        repeat (5) @(negedge CLK);

        for (int v = 0; v < 6; v++) begin
            clr();
            send_frame(vt[v].data, vt[v].stop, ^vt[v].data, vt[v].hold);
            repeat (20) @(negedge CLK);
            chk($sformatf("vec%0d valid count", v), n_valid, vt[v].exp_valid);
            chk($sformatf("vec%0d ferr count", v), n_ferr, vt[v].exp_ferr);
            chk($sformatf("vec%0d rx_data", v), int'(rx_data), int'(vt[v].exp_data));
            chk($sformatf("vec%0d rx_busy idle", v), int'(rx_busy), 0);
`ifdef UART_RX_PARITY_EN
            chk($sformatf("vec%0d perr count", v), n_perr, 0);
`endif
            if (vt[v].exp_valid == 1) begin
                chk($sformatf("vec%0d latency in window", v),
                    int'(lat >= LAT - 1 && lat <= LAT + 1), 1);
            end
        end

        // Back-to-back frames with no gap after the first stop bit.
        clr();
        busy_lo = 0;
        fork
            begin
                send_frame(8'h00, 1'b1, 1'b0, 0);
                send_frame(8'hFF, 1'b1, 1'b0, 0);
            end
            begin
                repeat (20) @(negedge CLK);
                meas = 1'b1;
                for (int k = 0; k < 300 && n_valid < 2; k++) @(negedge CLK);
                meas = 1'b0;
            end
        join
        repeat (20) @(negedge CLK);
        chk("b2b valid count", n_valid, 2);
        chk("b2b first byte", (cap.size() > 0) ? int'(cap[0]) : -1, 8'h00);
        chk("b2b second byte", (cap.size() > 1) ? int'(cap[1]) : -1, 8'hFF);
        chk("b2b busy gap bounded", int'(busy_lo >= 1 && busy_lo <= CPB / 2 + 1), 1);
        chk("b2b second latency", int'(lat >= LAT - 1 && lat <= LAT + 1), 1);

        // Three-cycle low glitch must be rejected.
        clr();
        RXD = 1'b0;
        repeat (3) @(negedge CLK);
        RXD = 1'b1;
        begin
            int w;
            w = 0;
            while (w < 8 && (rx_busy || w < 1)) begin
                @(negedge CLK);
                w++;
            end
            chk("glitch busy back to idle", int'(rx_busy), 0);
        end
        repeat (40) @(negedge CLK);
        chk("glitch saw busy", int'(n_busy_hi > 0), 1);
        chk("glitch valid count", n_valid, 0);
        chk("glitch ferr count", n_ferr, 0);

        // Reset during data bit 4 of 0xC3, then a clean 0x81.
        clr();
        fork
            send_frame(8'hC3, 1'b1, ^8'hC3, 0);
            begin
                repeat (CPB * 5 + 4) @(negedge CLK);
                reset = 1'b0;
                repeat (2) @(negedge CLK);
                reset = 1'b1;
                chk("mid reset rx_data", int'(rx_data), 8'h00);
                chk("mid reset rx_busy", int'(rx_busy), 0);
            end
        join
        repeat (30) @(negedge CLK);
        chk("aborted valid count", n_valid, 0);
        chk("aborted ferr count", n_ferr, 0);
        chk("aborted rx_data", int'(rx_data), 8'h00);
        clr();
        send_frame(8'h81, 1'b1, ^8'h81, 0);
        repeat (20) @(negedge CLK);
        chk("post reset valid count", n_valid, 1);
        chk("post reset rx_data", int'(rx_data), 8'h81);

`ifdef UART_RX_PARITY_EN
        clr();
        send_frame(8'h07, 1'b1, 1'b0, 0);
        repeat (20) @(negedge CLK);
        chk("bad parity valid count", n_valid, 1);
        chk("bad parity rx_data", int'(rx_data), 8'h07);
        chk("bad parity perr count", n_perr, 1);
        clr();
        send_frame(8'h07, 1'b1, 1'b1, 0);
        repeat (20) @(negedge CLK);
        chk("good parity valid count", n_valid, 1);
        chk("good parity perr count", n_perr, 0);
`endif

        chk("valid and ferr overlap", n_both, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
